// File: rtl/hp_key_sequencer.sv
// hp_key_sequencer: buffers key events in a FIFO and presents them one at a time to the core
// with a minimum hold time and a release gap between keys.
module hp_key_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int KEY_W      = 8,
    parameter int HOLD_CYC   = 2080,
    parameter int GAP_CYC    = 1040
) (
    input  logic                          clk_in,
    input  logic                          reset_n_in,
    input  logic                          key_valid_in,
    input  logic [KEY_W-1:0]              keycode_in,
    output logic                          key_ready_o,
    output logic                          key_pending_o,
    output logic [KEY_W-1:0]              keycode_o,
    input  logic                          key_ack_in,
    output logic                          overflow_o,
    input  logic                          clear_overflow_in,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int CMAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

    state_t           state;
    logic [KEY_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             ack_seen, full, push, pop, ack;

    assign full        = fifo_level_o == LW'(FIFO_DEPTH);
    assign key_ready_o = !full;
    assign push        = key_valid_in && !full;
    assign pop         = state == IDLE && fifo_level_o != '0;
    assign ack         = ack_seen || key_ack_in;

    always_ff @(posedge clk_in)
        if (push) mem[wr_ptr] <= keycode_in;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level_o  <= '0;
            cnt           <= '0;
            ack_seen      <= 1'b0;
            key_pending_o <= 1'b0;
            keycode_o     <= '0;
            overflow_o    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_level_o <= (push && !pop) ? fifo_level_o + 1'b1 :
                            (!push && pop) ? fifo_level_o - 1'b1 : fifo_level_o;
            // A dropped event in the same cycle as a clear keeps the flag set
            overflow_o <= (key_valid_in && full) ? 1'b1 :
                          clear_overflow_in ? 1'b0 : overflow_o;
            case (state)
                IDLE: if (pop) begin
                    keycode_o     <= mem[rd_ptr];
                    cnt           <= '0;
                    ack_seen      <= 1'b0;
                    key_pending_o <= 1'b1;
                    state         <= PRESENT;
                end
                PRESENT: if (ack && cnt >= CW'(HOLD_CYC - 1)) begin
                    cnt           <= '0;
                    key_pending_o <= 1'b0;
                    state         <= GAP;
                end else begin
                    cnt      <= (&cnt) ? cnt : cnt + 1'b1;
                    ack_seen <= ack;
                end
                GAP: if (cnt == CW'(GAP_CYC - 1)) state <= IDLE;
                     else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hp_key_sequencer.sv
// tb_hp_key_sequencer: directed checks of hold/gap timing, ordering, overflow and reset.
module tb_hp_key_sequencer;
    localparam int HOLD = 4;
    localparam int GAPC = 3;

    logic       clk_in = 1'b0;
    logic       reset_n_in = 1'b0;
    logic       key_valid_in = 1'b0;
    logic [7:0] keycode_in = '0;
    logic       key_ready_o, key_pending_o, overflow_o;
    logic [7:0] keycode_o;
    logic       key_ack_in = 1'b0;
    logic       clear_overflow_in = 1'b0;
    logic [2:0] fifo_level_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    hp_key_sequencer #(.FIFO_DEPTH(4), .KEY_W(8), .HOLD_CYC(HOLD), .GAP_CYC(GAPC)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .key_valid_in(key_valid_in),
        .keycode_in(keycode_in), .key_ready_o(key_ready_o), .key_pending_o(key_pending_o),
        .keycode_o(keycode_o), .key_ack_in(key_ack_in), .overflow_o(overflow_o),
        .clear_overflow_in(clear_overflow_in), .fifo_level_o(fifo_level_o)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int c);
        for (int i = 0; i < c; i++) tick();
    endtask

    // Count cycles until pending drops, pulsing ack on iteration ack_at
    task automatic measure_high(input int ack_at, output int cyc);
        cyc = 0;
        do begin
            key_ack_in = (cyc == ack_at);
            tick();
            cyc++;
        end while (key_pending_o && cyc < 100);
        key_ack_in = 1'b0;
    endtask

    task automatic measure_low(output int cyc);
        cyc = 0;
        while (!key_pending_o && cyc < 50) begin
            tick();
            cyc++;
        end
    endtask

    task automatic push(input logic [7:0] code);
        key_valid_in = 1'b1;
        keycode_in   = code;
        tick();
        key_valid_in = 1'b0;
    endtask

    initial begin
        logic [7:0] burst [4];
        burst = '{8'h14, 8'h2B, 8'h09, 8'h4A};
        idle(2);
        check("rst_ready", key_ready_o, 1);
        check("rst_pending", key_pending_o, 0);
        check("rst_keycode", keycode_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_level", fifo_level_o, 0);
        reset_n_in = 1'b1;
        idle(2);

        // single key, ack in second pending cycle
        push(8'h14);
        check("t1_level_after_push", fifo_level_o, 1);
        check("t1_not_yet_pending", key_pending_o, 0);
        tick();
        check("t1_pending", key_pending_o, 1);
        check("t1_keycode", keycode_o, 8'h14);
        check("t1_level_popped", fifo_level_o, 0);
        measure_high(1, n);
        check("t1_hold", n, HOLD);
        idle(10);
        check("t1_stays_low", key_pending_o, 0);
        check("t1_keycode_held", keycode_o, 8'h14);

        // late ack
        push(8'h2B);
        tick();
        check("t2_keycode", keycode_o, 8'h2B);
        measure_high(20, n);
        check("t2_late_hold", n, 21);
        idle(8);

        // burst of four keys
        for (int i = 0; i < 4; i++) push(burst[i]);
        check("t3_level", fifo_level_o, 3);
        check("t3_ready", key_ready_o, 1);
        for (int k = 0; k < 4; k++) begin
            check("t3_pending", key_pending_o, 1);
            check("t3_order", keycode_o, burst[k]);
            measure_high(0, n);
            if (k > 0) check("t3_hold", n, HOLD);
            if (k < 3) begin
                measure_low(n);
                check("t3_low_period", n, GAPC + 1);
            end
        end
        idle(10);
        check("t3_drained", fifo_level_o, 0);

        // overflow while the first key is held without ack
        push(8'hA1);
        tick();
        check("t4_pending", key_pending_o, 1);
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
        check("t4_full_level", fifo_level_o, 4);
        check("t4_not_ready", key_ready_o, 0);
        check("t4_no_ovf_yet", overflow_o, 0);
        push(8'hEE);
        check("t4_ovf_set", overflow_o, 1);
        check("t4_level_kept", fifo_level_o, 4);
        idle(3);
        check("t4_ovf_sticky", overflow_o, 1);
        key_valid_in = 1'b1;
        clear_overflow_in = 1'b1;
        tick();
        key_valid_in = 1'b0;
        check("t4_set_wins", overflow_o, 1);
        tick();
        clear_overflow_in = 1'b0;
        check("t4_ovf_cleared", overflow_o, 0);
        measure_high(0, n);
        for (int k = 0; k < 4; k++) begin
            measure_low(n);
            check("t4_order", keycode_o, 8'hB0 + k);
            measure_high(0, n);
        end
        idle(12);
        check("t4_dropped_not_shown", key_pending_o, 0);
        check("t4_empty", fifo_level_o, 0);

        // push on the same edge as a pop
        key_valid_in = 1'b1;
        keycode_in   = 8'h55;
        tick();
        keycode_in   = 8'h38;
        tick();
        key_valid_in = 1'b0;
        check("t5_level_same", fifo_level_o, 1);
        check("t5_first", keycode_o, 8'h55);
        measure_high(0, n);
        measure_low(n);
        check("t5_gap", n, GAPC + 1);
        check("t5_second", keycode_o, 8'h38);
        measure_high(0, n);
        idle(8);

        // async reset while a key is pending with two queued
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("t6_pending", key_pending_o, 1);
        check("t6_queued", fifo_level_o, 2);
        #3 reset_n_in = 1'b0;
        #1;
        check("t6_rst_pending", key_pending_o, 0);
        check("t6_rst_level", fifo_level_o, 0);
        tick();
        reset_n_in = 1'b1;
        idle(12);
        check("t6_no_key_after", key_pending_o, 0);
        check("t6_level_after", fifo_level_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
